iomem_game_regs: RTL and testbench

IOMEM_GAME_REGS -- requirements
Module: iomem_game_regs

---
 rtl/iomem_game_pkg.sv | 18 +
 rtl/btn_debounce.sv | 51 +++++
 rtl/iomem_game_regs.sv | 147 ++++++++++++++
 tb/tb_iomem_game_regs.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_game_pkg.sv
// Shared constants for the game register block: register map offsets,
// CTRL/BTN_STATUS bit positions and parameter defaults.
package iomem_game_pkg;

  localparam logic [7:0] BASE_PAGE_DEF = 8'h04;
  localparam int NUM_POS_DEF  = 4;
  localparam int POS_W_DEF    = 10;
  localparam int NUM_BTN_DEF  = 4;
  localparam int DB_COUNT_DEF = 1000000;

  // register indices relative to NUM_POS
  localparam int REG_BTN_STATUS = 0;
  localparam int REG_CTRL       = 1;

  localparam int CTRL_SYNC = 0;
  localparam int FLAG_OFS  = 16;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, hold-time counter, debounced level
// and a single-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_COUNT = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DB_COUNT);
  localparam logic [CW-1:0] CNT_TOP = CW'(DB_COUNT - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          level_q, level_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_inc = cnt_q + CW'(1);
    cnt_d   = '0;
    level_d = level_q;
    rise_o  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_inc == CNT_TOP) begin
        level_d = ~level_q;
        rise_o  = ~level_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/iomem_game_regs.sv
// picosoc iomem slave: position shadow/active registers with optional
// frame-synchronous commit, debounced buttons with sticky press flags.
module iomem_game_regs
  import iomem_game_pkg::*;
#(
  parameter logic [7:0] BASE_PAGE = BASE_PAGE_DEF,
  parameter int NUM_POS  = NUM_POS_DEF,
  parameter int POS_W    = POS_W_DEF,
  parameter int NUM_BTN  = NUM_BTN_DEF,
  parameter int DB_COUNT = DB_COUNT_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     iomem_valid,
  output logic                     iomem_ready,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic [31:0]              iomem_rdata,
  input  logic [NUM_BTN-1:0]       btn,
  input  logic                     frame_start,
  output logic [NUM_POS*POS_W-1:0] pos_out,
  output logic                     irq
);

  localparam logic [5:0] IDX_BTN  = 6'(NUM_POS + REG_BTN_STATUS);
  localparam logic [5:0] IDX_CTRL = 6'(NUM_POS + REG_CTRL);

  logic [5:0]  idx;
  logic        access, wr_en;
  logic        is_pos, is_btn, is_ctrl;
  logic [31:0] smask, wmask, rd_val;

  logic [POS_W-1:0] shadow_q [NUM_POS];
  logic [POS_W-1:0] shadow_d [NUM_POS];
  logic [POS_W-1:0] active_q [NUM_POS];
  logic [POS_W-1:0] active_d [NUM_POS];

  logic        ready_q, ready_d;
  logic        armed_q, armed_d;
  logic        sync_q, sync_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic [NUM_BTN-1:0] level, rise, clr;
  logic [NUM_BTN-1:0] flag_q, flag_d;

  logic unused_addr;
  assign unused_addr = ^{iomem_addr[23:8], iomem_addr[1:0]};

  assign idx     = iomem_addr[7:2];
  assign is_pos  = idx < IDX_BTN;
  assign is_btn  = idx == IDX_BTN;
  assign is_ctrl = idx == IDX_CTRL;

  // armed_q blocks an access still held across reset release
  assign access = (iomem_addr[31:24] == BASE_PAGE) && iomem_valid &&
                  !ready_q && armed_q;
  assign wr_en  = access && (iomem_wstrb != 4'b0);

  assign smask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wmask = iomem_wdata & smask;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(
      .DB_COUNT(DB_COUNT)
    ) u_db (
      .clk    (clk),
      .resetn (resetn),
      .btn_i  (btn[b]),
      .level_o(level[b]),
      .rise_o (rise[b])
    );
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      is_pos: begin
        for (int i = 0; i < NUM_POS; i++)
          if (idx == 6'(i)) rd_val = 32'(shadow_q[i]);
      end
      is_btn: begin
        rd_val[NUM_BTN-1:0]          = level;
        rd_val[FLAG_OFS +: NUM_BTN] = flag_q;
      end
      is_ctrl: rd_val[CTRL_SYNC] = sync_q;
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    ready_d = access;
    rdata_d = access ? rd_val : rdata_q;
    armed_d = armed_q | ~iomem_valid;
    sync_d  = sync_q;
    clr     = '0;
    for (int i = 0; i < NUM_POS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = (!sync_q || frame_start) ? shadow_q[i] : active_q[i];
    end
    if (wr_en) begin
      for (int i = 0; i < NUM_POS; i++)
        if (is_pos && idx == 6'(i))
          shadow_d[i] = POS_W'((32'(shadow_q[i]) & ~smask) | wmask);
      if (is_ctrl && smask[CTRL_SYNC]) sync_d = iomem_wdata[CTRL_SYNC];
      if (is_btn) clr = wmask[FLAG_OFS +: NUM_BTN];
    end
    // a new press wins over a simultaneous clear
    flag_d = (flag_q & ~clr) | rise;
    irq_d  = |flag_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      armed_q <= 1'b0;
      sync_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
      flag_q  <= '0;
      for (int i = 0; i < NUM_POS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      ready_q  <= ready_d;
      armed_q  <= armed_d;
      sync_q   <= sync_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      flag_q   <= flag_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  for (genvar g = 0; g < NUM_POS; g++) begin : g_pos
    assign pos_out[g*POS_W +: POS_W] = active_q[g];
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_game_regs.sv
// Scoreboard bench for iomem_game_regs: random and directed bus traffic
// against a register-map model, plus button, decode and reset scenarios.
module tb_iomem_game_regs;

  localparam int NP = 4;
  localparam int PW = 10;
  localparam int NB = 4;
  localparam int DB = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = '0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [NB-1:0] btn = '0;
  logic        frame_start = 1'b0;
  logic [NP*PW-1:0] pos_out;
  logic        irq;

  always #5 clk = ~clk;

  iomem_game_regs #(
    .BASE_PAGE(8'h04), .NUM_POS(NP), .POS_W(PW),
    .NUM_BTN(NB), .DB_COUNT(DB)
  ) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .btn(btn), .frame_start(frame_start),
    .pos_out(pos_out), .irq(irq)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  logic [PW-1:0] m_shadow[NP];
  logic [PW-1:0] m_active[NP];
  bit            m_sync;
  logic [NB-1:0] m_level, m_flag;
  logic [31:0]   m_last;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] A(int i);
    return {8'h04, 16'h0, 6'(i), 2'b00};
  endfunction

  function automatic logic [31:0] m_read(int idx);
    if (idx < NP) return {22'b0, m_shadow[idx]};
    if (idx == NP) return {12'b0, m_flag, 12'b0, m_level};
    if (idx == NP + 1) return {31'b0, m_sync};
    return 32'h0;
  endfunction

  function automatic void m_write(int idx, logic [31:0] d, logic [3:0] s);
    logic [31:0] v;
    if (idx < NP) begin
      v = {22'b0, m_shadow[idx]};
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      m_shadow[idx] = v[PW-1:0];
    end else if (idx == NP) begin
      for (int i = 0; i < NB; i++)
        if (s[(16+i)/8] && d[16+i]) m_flag[i] = 1'b0;
    end else if (idx == NP + 1) begin
      if (s[0]) m_sync = d[0];
    end
  endfunction

  function automatic void m_commit();
    for (int i = 0; i < NP; i++) m_active[i] = m_shadow[i];
  endfunction

  function automatic logic [63:0] m_pos();
    return {24'b0, m_active[3], m_active[2], m_active[1], m_active[0]};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_sync = 0; m_level = '0; m_flag = '0; m_last = '0;
  endfunction

  task automatic chk_pos(string name);
    chk(name, {24'b0, pos_out}, m_pos());
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // called at posedge+1; the access is sampled on the next edge
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, input bit fs = 0);
    int  idx;
    bit  got;
    logic [31:0] e;
    idx = int'(addr[7:2]);
    got = 0;
    e = m_read(idx);
    exp_q.push_back(e);
    m_last = e;
    if (!m_sync || fs) m_commit();
    m_write(idx, wd, st);
    iomem_addr = addr; iomem_wdata = wd; iomem_wstrb = st;
    iomem_valid = 1'b1; frame_start = fs;
    for (int n = 0; n < 8 && !got; n++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      got = iomem_ready;
    end
    iomem_valid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL bus_timeout addr=%0h no ready after 8 cycles", addr);
      void'(exp_q.pop_back());
    end else begin
      chk_pos("pos_at_ready");
    end
    @(posedge clk); #1;
    if (!m_sync) m_commit();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    m_commit();
  endtask

  bit prev_ready = 0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (iomem_ready) begin
      chk("ready_pulse", {63'b0, prev_ready}, 64'h0);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready rdata=%0h required=no ready", iomem_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", {32'b0, iomem_rdata}, {32'b0, e});
      end
    end
    prev_ready = iomem_ready;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit seen;
    m_reset();
    #1;
    chk("rst_ready", {63'b0, iomem_ready}, 64'h0);
    chk("rst_rdata", {32'b0, iomem_rdata}, 64'h0);
    chk("rst_irq", {63'b0, irq}, 64'h0);
    chk_pos("rst_pos");
    cyc(2);
    resetn = 1'b1;
    cyc(2);

    // write 0x3FF to ch1 via low two byte lanes
    bus(A(1), 32'h0000_03FF, 4'b0011);
    chk("w036_pos_ch1", {54'b0, pos_out[2*PW-1:PW]}, 64'h3FF);
    chk_pos("w036_pos");
    bus(A(1), 32'h0, 4'b0);

    // frame-synchronous commit
    bus(A(0), 32'd5, 4'b0011);
    bus(A(NP+1), 32'h1, 4'b0001);
    bus(A(0), 32'd200, 4'b0011);
    cyc(5);
    chk("sync_hold_ch0", {54'b0, pos_out[PW-1:0]}, 64'd5);
    pulse_frame();
    chk("sync_commit_ch0", {54'b0, pos_out[PW-1:0]}, 64'd200);
    bus(A(0), 32'd300, 4'b0011, 1'b1);
    chk("sync_coincide_ch0", {54'b0, pos_out[PW-1:0]}, 64'd200);
    pulse_frame();
    chk("sync_next_ch0", {54'b0, pos_out[PW-1:0]}, 64'd300);

    for (int k = 0; k < 80; k++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op < 5)
        bus(A(int'($urandom_range(0, NP-1))), $urandom,
            4'($urandom_range(0, 15)), bit'($urandom_range(0, 3) == 0));
      else if (op < 7)
        bus(A(int'($urandom_range(0, NP-1))), 32'h0, 4'b0);
      else if (op == 7)
        bus(A(NP+1), $urandom, 4'($urandom_range(0, 15)));
      else if (op == 8)
        pulse_frame();
      else if (op == 9)
        bus(A(NP), $urandom, 4'($urandom_range(0, 15)));
      else
        bus(A(int'($urandom_range(NP+2, 63))), $urandom, 4'hF);
      chk_pos("pos_rand");
    end

    // debounce: short glitch, then a real press
    btn = 4'b0100;
    cyc(5);
    btn = 4'b0000;
    cyc(20);
    bus(A(NP), 32'h0, 4'b0);
    chk("glitch_irq", {63'b0, irq}, 64'h0);
    btn = 4'b0100;
    cyc(14);
    m_level[2] = 1'b1; m_flag[2] = 1'b1;
    bus(A(NP), 32'h0, 4'b0);
    chk("press_irq", {63'b0, irq}, 64'h1);

    // write-1-to-clear
    bus(A(NP), 32'h0004_0000, 4'b0100);
    chk("w1c_irq", {63'b0, irq}, 64'h0);
    bus(A(NP), 32'h0, 4'b0);
    btn = 4'b0000;
    cyc(20);
    m_level[2] = 1'b0;
    bus(A(NP), 32'h0, 4'b0);

    // find the edge on which a press sets its flag
    btn = 4'b0100;
    r = 0;
    while (!irq && r < 40) begin
      @(posedge clk); #1;
      r++;
    end
    if (!irq) begin
      checks++; failures++;
      $display("FAIL press_timeout irq=0 required=1 within 40 cycles");
      r = 10;
    end
    m_level[2] = 1'b1; m_flag[2] = 1'b1;
    cyc(4);
    bus(A(NP), 32'h0004_0000, 4'b0100);
    btn = 4'b0000;
    cyc(20);
    m_level[2] = 1'b0;
    // clear lands on the same edge as the new press
    btn = 4'b0100;
    cyc(r - 1);
    bus(A(NP), 32'h0004_0000, 4'b0100);
    m_level[2] = 1'b1; m_flag[2] = 1'b1;
    cyc(3);
    bus(A(NP), 32'h0, 4'b0);
    chk("set_wins_irq", {63'b0, irq}, 64'h1);

    // unselected page and unmapped index
    iomem_addr = 32'h0300_0010; iomem_wdata = 32'hFFFF_FFFF;
    iomem_wstrb = 4'hF; iomem_valid = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1;
    end
    iomem_valid = 1'b0;
    chk("unsel_ready", {63'b0, seen}, 64'h0);
    chk("unsel_rdata", {32'b0, iomem_rdata}, {32'b0, m_last});
    cyc(1);
    bus(A(NP+5), 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < NP + 2; i++) bus(A(i), 32'h0, 4'b0);
    chk_pos("unmapped_pos");

    // reset in the middle of an access
    btn = 4'b0000;
    cyc(20);
    m_level[2] = 1'b0;
    iomem_addr = A(0); iomem_wstrb = 4'b0; iomem_valid = 1'b1;
    #2 resetn = 1'b0;
    #1;
    m_reset();
    chk("midrst_ready", {63'b0, iomem_ready}, 64'h0);
    chk("midrst_rdata", {32'b0, iomem_rdata}, 64'h0);
    chk("midrst_irq", {63'b0, irq}, 64'h0);
    chk_pos("midrst_pos");
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1;
    end
    chk("abort_no_ready", {63'b0, seen}, 64'h0);
    iomem_valid = 1'b0;
    cyc(1);
    bus(A(0), 32'h0, 4'b0);
    bus(A(NP), 32'h0, 4'b0);
    bus(A(NP+1), 32'h0, 4'b0);
    cyc(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
